// File: rtl/as_notify_defs.sv
// Shared constants for the spoof-notification transmitter: IOQ header field
// positions, notification packet geometry and the transmit FSM encoding.
package as_notify_defs;

  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
  localparam int IOQ_BYTE_LEN_POS = 0;
  localparam int IOQ_SRC_PORT_POS = 16;
  localparam int IOQ_WORD_LEN_POS = 32;
  localparam int IOQ_DST_PORT_POS = 48;

  localparam int NOTIFY_WORDS = 8;
  localparam int NOTIFY_BYTES = 64;
  localparam logic [2:0] LAST_WORD = 3'(NOTIFY_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } notify_state_t;

endpackage

// File: rtl/as_notify_req_fifo.sv
// Register FIFO for pending notification requests. Head is valid whenever
// o_empty is low; a push alongside a pop is accepted even when full.
module as_notify_req_fifo #(
  parameter int WIDTH      = 115,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_BITS:0] r_wr_ptr;
  logic [DEPTH_BITS:0] r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                     (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // The slot freed by a same-cycle pop is the one the push reuses.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/as_spoof_notify_tx.sv
// Turns spoof-drop events into fixed 64-byte notification packets (IOQ header
// plus 8 data words) written onto the datapath under out_rdy flow control.
module as_spoof_notify_tx
  import as_notify_defs::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_IQ_BITS       = 3,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] NOTIFY_DST_PORTS = 8'b10101010,
  parameter logic [15:0] NOTIFY_ETHERTYPE = 16'h88B5,
  parameter logic [47:0] NOTIFY_MAC       = 48'h0000_4E46_0000,
  parameter int REQ_DEPTH_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   notify_en,
  input  logic                   drop_vld,
  input  logic [47:0]            drop_src_mac,
  input  logic [31:0]            drop_src_ip,
  input  logic [31:0]            drop_dst_ip,
  input  logic [NUM_IQ_BITS-1:0] drop_src_port,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic                   out_wr,
  input  logic                   out_rdy,
  output logic                   notify_sent,
  output logic [31:0]            overflow_cnt,
  output notify_state_t          o_dbg_state
);

  localparam int REQ_W = 48 + 32 + 32 + NUM_IQ_BITS;

  notify_state_t    r_state;
  logic [2:0]       r_word_idx;
  logic [15:0]      r_seq_num;
  logic [31:0]      r_overflow_cnt;
  logic [31:0]      r_ovf_snap;

  logic             w_event;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [REQ_W-1:0] w_head;
  logic [47:0]      w_head_mac;
  logic [31:0]      w_head_sip;
  logic [31:0]      w_head_dip;
  logic [NUM_IQ_BITS-1:0] w_head_port;
  logic [63:0]      w_data;
  logic [7:0]       w_ctrl;

  assign w_event = drop_vld && notify_en;
  assign w_pop   = (r_state == ST_DATA) && out_rdy && (r_word_idx == LAST_WORD);
  assign w_push  = w_event;

  as_notify_req_fifo #(
    .WIDTH      (REQ_W),
    .DEPTH_BITS (REQ_DEPTH_BITS)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({drop_src_mac, drop_src_ip, drop_dst_ip, drop_src_port}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_mac, w_head_sip, w_head_dip, w_head_port} = w_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow_cnt <= '0;
    end else if (w_event && w_full && !w_pop && (r_overflow_cnt != 32'hFFFF_FFFF)) begin
      r_overflow_cnt <= r_overflow_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_seq_num  <= '0;
      r_ovf_snap <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_empty) r_state <= ST_HDR;
        ST_HDR: if (out_rdy) begin
          r_state    <= ST_DATA;
          r_word_idx <= '0;
          r_ovf_snap <= r_overflow_cnt;
        end
        ST_DATA: if (out_rdy) begin
          if (r_word_idx == LAST_WORD) begin
            r_state   <= ST_IDLE;
            r_seq_num <= r_seq_num + 16'd1;
          end else begin
            r_word_idx <= r_word_idx + 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Word contents depend only on state, index and FIFO head, so a stalled
  // word is re-presented unchanged until out_rdy accepts it.
  always_comb begin
    w_data = '0;
    w_ctrl = '0;
    case (r_state)
      ST_HDR: begin
        w_data[IOQ_BYTE_LEN_POS +: 16] = 16'(NOTIFY_BYTES);
        w_data[IOQ_SRC_PORT_POS +: 16] = 16'(w_head_port);
        w_data[IOQ_WORD_LEN_POS +: 16] = 16'(NOTIFY_WORDS);
        w_data[IOQ_DST_PORT_POS +: 16] = 16'(NOTIFY_DST_PORTS);
        w_ctrl = IO_QUEUE_STAGE_NUM;
      end
      ST_DATA: begin
        case (r_word_idx)
          3'd0:    w_data = {48'hFFFF_FFFF_FFFF, NOTIFY_MAC[47:32]};
          3'd1:    w_data = {NOTIFY_MAC[31:0], NOTIFY_ETHERTYPE, r_seq_num};
          3'd2:    w_data = {w_head_mac, 16'(w_head_port)};
          3'd3:    w_data = {w_head_sip, w_head_dip};
          3'd4:    w_data = {32'd0, r_ovf_snap};
          default: w_data = '0;
        endcase
        if (r_word_idx == LAST_WORD) w_ctrl = 8'h01;
      end
      default: ;
    endcase
  end

  assign out_wr       = (r_state != ST_IDLE) && out_rdy;
  assign out_data     = w_data;
  assign out_ctrl     = w_ctrl;
  assign notify_sent  = w_pop;
  assign overflow_cnt = r_overflow_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_as_spoof_notify_tx.sv
// Bench for as_spoof_notify_tx: directed scenarios plus a random stream, all
// judged against a packet-level model of the notification rules.
module tb_as_spoof_notify_tx;
  import as_notify_defs::*;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [2:0]  port;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          notify_en;
  logic          drop_vld;
  logic [47:0]   drop_src_mac;
  logic [31:0]   drop_src_ip;
  logic [31:0]   drop_dst_ip;
  logic [2:0]    drop_src_port;
  logic [63:0]   out_data;
  logic [7:0]    out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          notify_sent;
  logic [31:0]   overflow_cnt;
  notify_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  ev_t         exp_q[$];
  int          wcnt = 0;
  logic [15:0] exp_seq = '0;
  logic [31:0] exp_ovf = '0;
  logic [31:0] hdr_snap = '0;
  int          cyc = 0;
  int          hdr_cyc = 0;
  int          last_cyc = 0;
  int          wr_seen = 0;

  as_spoof_notify_tx dut (
    .clk           (clk),
    .reset         (reset),
    .notify_en     (notify_en),
    .drop_vld      (drop_vld),
    .drop_src_mac  (drop_src_mac),
    .drop_src_ip   (drop_src_ip),
    .drop_dst_ip   (drop_dst_ip),
    .drop_src_port (drop_src_port),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .notify_sent   (notify_sent),
    .overflow_cnt  (overflow_cnt),
    .o_dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // idx 0 is the IOQ header, 1..8 are data words 0..7.
  function automatic logic [63:0] exp_word(input ev_t e, input int idx,
                                           input logic [15:0] seq, input logic [31:0] snap);
    case (idx)
      0: return {16'h00AA, 16'd8, 13'd0, e.port, 16'd64};
      1: return 64'hFFFF_FFFF_FFFF_0000;
      2: return {32'h4E46_0000, 16'h88B5, seq};
      3: return {e.mac, 13'd0, e.port};
      4: return {e.sip, e.dip};
      5: return {32'd0, snap};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [7:0] exp_ctrl(input int idx);
    if (idx == 0) return 8'hFF;
    if (idx == 8) return 8'h01;
    return 8'h00;
  endfunction

  // Model: queue of accepted-but-unfinished events stands in for the request FIFO.
  always @(negedge clk) begin
    logic exp_sent;
    if (reset) begin
      exp_q.delete();
      wcnt    = 0;
      exp_seq = '0;
      exp_ovf = '0;
    end else begin
      exp_sent = 1'b0;
      check("wr_implies_rdy", {63'd0, out_wr & ~out_rdy}, 64'd0);
      check("overflow_cnt", {32'd0, overflow_cnt}, {32'd0, exp_ovf});
      if (out_wr) wr_seen++;
      if (exp_q.size() == 0) begin
        check("no_packet_pending_wr", {63'd0, out_wr}, 64'd0);
      end else if (out_wr) begin
        if (wcnt == 0) begin
          hdr_snap = exp_ovf;
          hdr_cyc  = cyc;
        end
        check($sformatf("word%0d_data", wcnt), out_data, exp_word(exp_q[0], wcnt, exp_seq, hdr_snap));
        check($sformatf("word%0d_ctrl", wcnt), {56'd0, out_ctrl}, {56'd0, exp_ctrl(wcnt)});
        if (wcnt == 8) begin
          exp_sent = 1'b1;
          last_cyc = cyc;
          void'(exp_q.pop_front());
          exp_seq = exp_seq + 16'd1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      check("notify_sent", {63'd0, notify_sent}, {63'd0, exp_sent});
      if (drop_vld && notify_en) begin
        if (exp_q.size() < 4)
          exp_q.push_back('{mac: drop_src_mac, sip: drop_src_ip, dip: drop_dst_ip, port: drop_src_port});
        else if (exp_ovf != 32'hFFFF_FFFF)
          exp_ovf = exp_ovf + 32'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_event(input logic [47:0] mac, input logic [31:0] sip,
                            input logic [31:0] dip, input logic [2:0] port);
    drop_vld      = 1'b1;
    drop_src_mac  = mac;
    drop_src_ip   = sip;
    drop_dst_ip   = dip;
    drop_src_port = port;
    tick();
    drop_vld = 1'b0;
  endtask

  task automatic send_rand_event();
    send_event({$urandom, $urandom} >> 16, $urandom, $urandom, 3'($urandom_range(0, 7)));
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int ev_cyc;
    int wr_before;
    reset = 1'b1; notify_en = 1'b1; drop_vld = 1'b0; out_rdy = 1'b1;
    drop_src_mac = '0; drop_src_ip = '0; drop_dst_ip = '0; drop_src_port = '0;
    tick(); tick();
    check("reset_out_wr", {63'd0, out_wr}, 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("reset_overflow", {32'd0, overflow_cnt}, 64'd0);
    reset = 1'b0;
    tick(); tick();

    // Single event with latency measurement.
    ev_cyc = cyc;
    send_event(48'h0011_2233_4455, 32'h0A00_0001, 32'h0A00_0002, 3'd2);
    drain(40);
    check("latency_header", 64'(hdr_cyc - ev_cyc), 64'd2);
    check("latency_last", 64'(last_cyc - ev_cyc), 64'd10);

    // out_rdy alternating every cycle.
    send_rand_event();
    for (int i = 0; i < 30; i++) begin
      out_rdy = ~out_rdy;
      tick();
    end
    out_rdy = 1'b1;
    drain(40);

    // Six back-to-back events while stalled: four queue, two overflow.
    tick();
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) send_rand_event();
    tick();
    check("ovf_after_burst", {32'd0, overflow_cnt}, 64'd2);
    out_rdy = 1'b1;
    drain(200);

    // Full FIFO with a push landing on the last-word pop.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_rand_event();
    tick();
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    send_rand_event();
    check("ovf_push_on_pop", {32'd0, overflow_cnt}, 64'd2);
    drain(200);
    check("seq_after_batches", {48'd0, exp_seq}, 64'd11);

    // Reset during data word 3 abandons the packet.
    send_rand_event();
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    check("midreset_out_wr", {63'd0, out_wr}, 64'd0);
    check("midreset_out_data", out_data, 64'd0);
    check("midreset_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("midreset_notify_sent", {63'd0, notify_sent}, 64'd0);
    check("midreset_overflow", {32'd0, overflow_cnt}, 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    send_rand_event();
    drain(40);

    // Notifications disabled: events ignored, nothing counted.
    notify_en = 1'b0;
    wr_before = wr_seen;
    for (int i = 0; i < 3; i++) send_rand_event();
    for (int i = 0; i < 15; i++) tick();
    check("disabled_no_wr", 64'(wr_seen - wr_before), 64'd0);
    check("disabled_no_ovf", {32'd0, overflow_cnt}, 64'd0);
    notify_en = 1'b1;

    // Random stream with random back-pressure and enable.
    for (int i = 0; i < 300; i++) begin
      out_rdy   = ($urandom_range(0, 9) < 7);
      notify_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) send_rand_event();
      else tick();
    end
    out_rdy   = 1'b1;
    notify_en = 1'b1;
    drain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
